ram_req_ctrl: RTL and testbench

//  Requester-side controller for one port of the dual-port block RAM wrapper.
//  - Turns a valid/ready request stream (single writes, single/burst reads) into RAM port strobes.
//  - Absorbs the RAM's 1-cycle read latency and returns read data on a valid/ready response stream.
//  - One instance sits in front of port A or port B; the two instances are independent.

---
 rtl/ram_req_ctrl_pkg.sv | 14 +
 rtl/ram_req_ctrl_if.sv | 28 ++
 rtl/ram_req_ctrl_rsp_fifo.sv | 59 +++++
 rtl/ram_req_ctrl.sv | 152 +++++++++++++++
 tb/tb_ram_req_ctrl.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_req_ctrl_pkg.sv
// Shared types and default widths for the RAM requester controller and its response FIFO.
package ram_req_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_RD_BURST = 1'b1
  } state_e;

  localparam int unsigned DEF_WIDTHAD   = 16;
  localparam int unsigned DEF_WIDTH     = 32;
  localparam int unsigned DEF_LEN_W     = 8;
  localparam int unsigned DEF_RSP_DEPTH = 4;

endpackage

// File: rtl/ram_req_ctrl_if.sv
// Request/response stream bundle between a requester (master) and ram_req_ctrl (slave).
interface ram_req_ctrl_if #(
  parameter int unsigned WIDTHAD = ram_req_ctrl_pkg::DEF_WIDTHAD,
  parameter int unsigned WIDTH   = ram_req_ctrl_pkg::DEF_WIDTH,
  parameter int unsigned LEN_W   = ram_req_ctrl_pkg::DEF_LEN_W
);

  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [WIDTHAD-1:0] req_addr;
  logic [WIDTH-1:0]   req_wdata;
  logic [LEN_W-1:0]   req_len;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/ram_req_ctrl_rsp_fifo.sv
// Register FIFO with first-word-fall-through output; holds read data until the consumer takes it.
module ram_req_ctrl_rsp_fifo
  import ram_req_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_RSP_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop && !o_empty;
  // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem   <= '{default: '0};
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/ram_req_ctrl.sv
// Requester-side controller for one block-RAM port: request stream in, registered RAM strobes out,
// read data back through a credit-checked response FIFO.
module ram_req_ctrl
  import ram_req_ctrl_pkg::*;
#(
  parameter int unsigned WIDTHAD   = DEF_WIDTHAD,
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned LEN_W     = DEF_LEN_W,
  parameter int unsigned RSP_DEPTH = DEF_RSP_DEPTH
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  ram_req_ctrl_if.slave      io_bus,
  output logic               o_busy,
  output logic [WIDTHAD-1:0] o_ram_address,
  output logic               o_ram_wren,
  output logic [WIDTH-1:0]   o_ram_data,
  output logic               o_ram_rden,
  input  logic [WIDTH-1:0]   i_ram_q
);

  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
  localparam int unsigned IW = CW + 1;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [WIDTHAD-1:0] r_addr;
  logic [WIDTHAD-1:0] w_addr_nxt;
  logic [LEN_W-1:0]   r_beat_cnt;
  logic [LEN_W-1:0]   w_beat_nxt;
  logic [WIDTHAD-1:0] r_ram_address;
  logic [WIDTHAD-1:0] w_ram_address_nxt;
  logic [WIDTH-1:0]   r_ram_data;
  logic [WIDTH-1:0]   w_ram_data_nxt;
  logic               r_ram_wren;
  logic               w_ram_wren_nxt;
  logic               r_ram_rden;
  logic               w_ram_rden_nxt;
  logic               r_cap;
  logic               r_run;
  logic               w_req_ready;
  logic               w_credit;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [CW-1:0]      w_count;
  logic [IW-1:0]      w_inflight;
  logic [WIDTH-1:0]   w_fifo_data;

  // Reads in flight (issue stage r_ram_rden, capture stage r_cap) already own a FIFO slot.
  assign w_inflight = IW'(w_count) + IW'(r_ram_rden) + IW'(r_cap);
  assign w_credit   = !w_full && (w_inflight < IW'(RSP_DEPTH));

  always_comb begin
    w_state_nxt       = r_state;
    w_addr_nxt        = r_addr;
    w_beat_nxt        = r_beat_cnt;
    w_ram_address_nxt = r_ram_address;
    w_ram_data_nxt    = r_ram_data;
    w_ram_wren_nxt    = 1'b0;
    w_ram_rden_nxt    = 1'b0;
    w_req_ready       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_req_ready = r_run && w_credit;
        if (io_bus.req_valid && w_req_ready) begin
          w_ram_address_nxt = io_bus.req_addr;
          if (io_bus.req_we) begin
            w_ram_wren_nxt = 1'b1;
            w_ram_data_nxt = io_bus.req_wdata;
          end else if (io_bus.req_len == '0) begin
            w_ram_rden_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_RD_BURST;
            w_beat_nxt  = io_bus.req_len;
            w_addr_nxt  = io_bus.req_addr;
          end
        end
      end
      ST_RD_BURST: begin
        if (w_credit) begin
          w_ram_rden_nxt    = 1'b1;
          w_ram_address_nxt = r_addr;
          w_addr_nxt        = r_addr + WIDTHAD'(1);
          if (r_beat_cnt == '0) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_beat_nxt = r_beat_cnt - LEN_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr        <= '0;
      r_beat_cnt    <= '0;
      r_ram_address <= '0;
      r_ram_data    <= '0;
      r_ram_wren    <= 1'b0;
      r_ram_rden    <= 1'b0;
      r_cap         <= 1'b0;
      r_run         <= 1'b0;
    end else begin
      r_addr        <= w_addr_nxt;
      r_beat_cnt    <= w_beat_nxt;
      r_ram_address <= w_ram_address_nxt;
      r_ram_data    <= w_ram_data_nxt;
      r_ram_wren    <= w_ram_wren_nxt;
      r_ram_rden    <= w_ram_rden_nxt;
      r_cap         <= r_ram_rden;
      r_run         <= 1'b1;
    end
  end

  ram_req_ctrl_rsp_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (r_cap),
    .i_data  (i_ram_q),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_pop            = !w_empty && io_bus.rsp_ready;
  assign io_bus.req_ready = w_req_ready;
  assign io_bus.rsp_valid = !w_empty;
  assign io_bus.rsp_data  = w_fifo_data;

  assign o_busy        = (r_state != ST_IDLE) || r_ram_rden || r_cap || !w_empty;
  assign o_ram_address = r_ram_address;
  assign o_ram_wren    = r_ram_wren;
  assign o_ram_data    = r_ram_data;
  assign o_ram_rden    = r_ram_rden;

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Directed bench for ram_req_ctrl against a behavioural NEW_DATA RAM with 1-cycle read latency.
module tb_ram_req_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_req_ctrl_if #(.WIDTHAD(16), .WIDTH(32), .LEN_W(8)) bus ();

  logic        busy;
  logic [15:0] ram_address;
  logic        ram_wren;
  logic [31:0] ram_data;
  logic        ram_rden;
  logic [31:0] ram_q;

  ram_req_ctrl #(
    .WIDTHAD   (16),
    .WIDTH     (32),
    .LEN_W     (8),
    .RSP_DEPTH (4)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .io_bus        (bus),
    .o_busy        (busy),
    .o_ram_address (ram_address),
    .o_ram_wren    (ram_wren),
    .o_ram_data    (ram_data),
    .o_ram_rden    (ram_rden),
    .i_ram_q       (ram_q)
  );

  logic [31:0] ram_mem [0:65535];
  always @(posedge clk) begin
    if (ram_wren) ram_mem[ram_address] <= ram_data;
    if (ram_rden) ram_q <= ram_wren ? ram_data : ram_mem[ram_address];
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [31:0] ref_mem [bit [15:0]];
  logic [31:0] got_q[$];
  int          got_cyc[$];
  logic [31:0] exp_q[$];
  int          n_iss = 0;
  int          n_dlv = 0;
  int          max_out = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        rnd_rdy = 1'b0;

  // Response monitor: collects handshakes, checks hold-while-stalled and busy vs outstanding reads.
  always @(negedge clk) begin
    if (!rst_n) begin
      n_iss      = 0;
      n_dlv      = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_held", 32'(bus.rsp_valid), 32'd1);
        chk("stall_data_held", bus.rsp_data, prev_data);
      end
      if (ram_rden) n_iss++;
      if (bus.rsp_valid && bus.rsp_ready) begin
        got_q.push_back(bus.rsp_data);
        got_cyc.push_back(cyc);
        n_dlv++;
      end
      if (n_iss - n_dlv > max_out) max_out = n_iss - n_dlv;
      if (!busy && n_iss != n_dlv) chk("busy_low_with_reads_outstanding", n_iss - n_dlv, 0);
      prev_stall = bus.rsp_valid && !bus.rsp_ready;
      prev_data  = bus.rsp_data;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) bus.rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic send(input logic we, input logic [15:0] a, input logic [31:0] d,
                      input logic [7:0] len);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_len   = len;
    while (!bus.req_ready && n < 300) begin
      tick();
      n++;
    end
    if (!bus.req_ready) chk($sformatf("req_ready_timeout_%04h", a), 32'(bus.req_ready), 32'd1);
    if (we) ref_mem[a] = d;
    else for (int i = 0; i <= int'(len); i++) exp_q.push_back(ref_mem[16'(int'(a) + i)]);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input string tag);
    int k = 0;
    while (got_q.size() < n && k < 400) begin
      tick();
      k++;
    end
    if (got_q.size() < n) chk({tag, "_rsp_timeout"}, got_q.size(), n);
  endtask

  task automatic cmp_q(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    int          k;
    int          rdy_hi;
    logic [31:0] t3_exp [4];
    t3_exp = '{32'hA5A5_FFFE, 32'hA5A5_FFFF, 32'hA5A5_0000, 32'hA5A5_0001};

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_len   = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ram_wren", 32'(ram_wren), 32'd0);
    chk("rst_ram_rden", 32'(ram_rden), 32'd0);
    chk("rst_ram_address", 32'(ram_address), 32'd0);
    chk("rst_ram_data", ram_data, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("req_ready_before_first_edge", 32'(bus.req_ready), 32'd0);
    tick();
    chk("req_ready_after_release", 32'(bus.req_ready), 32'd1);

    // 1: write then single read, 3-cycle accept-to-response
    bus.rsp_ready = 1'b1;
    clear_q();
    send(1'b1, 16'h0010, 32'hDEAD_BEEF, 8'd0);
    chk("t1_wren", 32'(ram_wren), 32'd1);
    chk("t1_wr_addr", 32'(ram_address), 32'h10);
    chk("t1_wr_data", ram_data, 32'hDEAD_BEEF);
    send(1'b0, 16'h0010, 32'h0, 8'd0);
    chk("t1_rden", 32'(ram_rden), 32'd1);
    chk("t1_rd_addr", 32'(ram_address), 32'h10);
    chk("t1_valid_e1", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("t1_valid_e2", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("t1_valid_e3", 32'(bus.rsp_valid), 32'd1);
    chk("t1_data", bus.rsp_data, 32'hDEAD_BEEF);
    repeat (2) tick();

    // 2: burst of 8 at full rate
    for (int i = 0; i < 8; i++) send(1'b1, 16'(i), 32'(i * 3), 8'd0);
    clear_q();
    send(1'b0, 16'h0000, 32'h0, 8'd7);
    rdy_hi = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.req_ready) rdy_hi++;
      tick();
    end
    chk("t2_req_ready_during_burst", rdy_hi, 0);
    wait_rsp(8, "t2");
    for (int i = 0; i < got_q.size() && i < 8; i++) begin
      chk($sformatf("t2_beat%0d", i), got_q[i], 32'(i * 3));
      chk($sformatf("t2_gap%0d", i), got_cyc[i] - got_cyc[0], i);
    end

    // 3: burst wrapping the address space
    send(1'b1, 16'hFFFE, 32'hA5A5_FFFE, 8'd0);
    send(1'b1, 16'hFFFF, 32'hA5A5_FFFF, 8'd0);
    send(1'b1, 16'h0000, 32'hA5A5_0000, 8'd0);
    send(1'b1, 16'h0001, 32'hA5A5_0001, 8'd0);
    clear_q();
    send(1'b0, 16'hFFFE, 32'h0, 8'd3);
    wait_rsp(4, "t3");
    for (int i = 0; i < got_q.size() && i < 4; i++)
      chk($sformatf("t3_beat%0d", i), got_q[i], t3_exp[i]);

    // 4: backpressure stalls issue at FIFO depth, then drains with toggling ready
    for (int i = 0; i < 16; i++) send(1'b1, 16'(16'h40 + i), 32'h4000_0000 + 32'(i), 8'd0);
    bus.rsp_ready = 1'b0;
    repeat (2) tick();
    clear_q();
    base = n_iss;
    send(1'b0, 16'h0040, 32'h0, 8'd15);
    repeat (12) tick();
    chk("t4_issued_while_stalled", n_iss - base, 4);
    chk("t4_rden_stalled", 32'(ram_rden), 32'd0);
    chk("t4_valid_stalled", 32'(bus.rsp_valid), 32'd1);
    chk("t4_head_data", bus.rsp_data, 32'h4000_0000);
    k = 0;
    while (got_q.size() < 16 && k < 300) begin
      bus.rsp_ready = ~bus.rsp_ready;
      tick();
      k++;
    end
    wait_rsp(16, "t4");
    for (int i = 0; i < got_q.size() && i < 16; i++)
      chk($sformatf("t4_beat%0d", i), got_q[i], 32'h4000_0000 + 32'(i));
    chk("t4_total_issued", n_iss - base, 16);
    bus.rsp_ready = 1'b1;
    repeat (3) tick();

    // 5: reset mid-burst, then a fresh read
    clear_q();
    base = n_iss;
    send(1'b0, 16'h0040, 32'h0, 8'd15);
    k = 0;
    while (n_iss - base < 5 && k < 50) begin
      tick();
      k++;
    end
    if (n_iss - base < 5) chk("t5_issue_timeout", n_iss - base, 5);
    rst_n = 1'b0;
    tick();
    chk("t5_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_rden", 32'(ram_rden), 32'd0);
    chk("t5_rst_req_ready", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    clear_q();
    send(1'b0, 16'h0010, 32'h0, 8'd0);
    wait_rsp(1, "t5");
    if (got_q.size() > 0) chk("t5_read_after_reset", got_q[0], 32'hDEAD_BEEF);
    cmp_q("t5");

    // 6: random mix against the scoreboard
    for (int i = 0; i < 16; i++) send(1'b1, 16'(16'h20 + i), $urandom, 8'd0);
    repeat (3) tick();
    clear_q();
    rnd_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0)
        send(1'b1, 16'(16'h20 + $urandom_range(0, 7)), $urandom, 8'd0);
      else
        send(1'b0, 16'(16'h20 + $urandom_range(0, 7)), 32'h0, 8'($urandom_range(0, 3)));
    end
    rnd_rdy = 1'b0;
    tick();
    bus.rsp_ready = 1'b1;
    wait_rsp(exp_q.size(), "t6");
    cmp_q("t6");
    repeat (4) tick();
    chk("t6_busy_drained", 32'(busy), 32'd0);
    chk("max_outstanding_within_depth", 32'(max_out <= 4), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
